// File: rtl/tft_pkg.sv
// Shared types and helpers for the 8080-style TFT bus master.
// Holds the sequencer state encoding and RGB565 colour widening.
package tft_pkg;

    typedef enum logic [2:0] {
        RST_LO,
        RST_WAIT,
        IDLE,
        SETUP,
        HOLD
    } state_t;

    localparam int R_W = 5;
    localparam int G_W = 6;
    localparam int B_W = 5;

    // Repeat the cw-bit value v MSB-first to fill tw bits (right-aligned).
    function automatic logic [5:0] widen(
        input logic [4:0] v,
        input int         cw,
        input int         tw
    );
        logic [5:0] w;
        w = '0;
        for (int i = 0; i < 6; i++) begin
            if (i < tw) w[tw-1-i] = v[cw-1-(i%cw)];
        end
        return w;
    endfunction

endpackage

// File: rtl/tft_word_fifo.sv
// Single-clock synchronous FIFO with registered occupancy.
// Exposes the head entry and the one behind it for back-to-back reads.
module tft_word_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic [W-1:0]             rd_next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_wr;
    logic          do_rd;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign do_wr   = wr_en && (!full || rd_en);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    assign rd_next = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tft_bus_master.sv
// Write-only 8080 parallel TFT master: panel reset sequence, word FIFO,
// RGB565 pixel packing and WR strobe generation on an 8/16-bit bus.
module tft_bus_master
    import tft_pkg::*;
#(
    parameter int BUS_W      = 16,
    parameter int CW         = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int WR_LOW     = 2,
    parameter int WR_HIGH    = 2,
    parameter int RST_CYCLES = 280000
) (
    input  logic                           clk28,
    input  logic                           rst_n,
    input  logic                           cmd_valid,
    input  logic                           cmd_rs,
    input  logic [15:0]                    cmd_data,
    output logic                           cmd_ready,
    input  logic                           pix_valid,
    input  logic [CW-1:0]                  pix_r,
    input  logic [CW-1:0]                  pix_g,
    input  logic [CW-1:0]                  pix_b,
    output logic                           pix_ready,
    output logic                           busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           tftRD,
    output logic                           tftWR,
    output logic                           tftRS,
    output logic                           tftRESET,
    output logic [BUS_W-1:0]               tftData
);

    localparam int LW    = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(RST_CYCLES + WR_LOW + WR_HIGH + 1);
    localparam int BEATS = 16 / BUS_W;

    localparam logic [CNT_W-1:0] RST_TC  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOW_TC  = CNT_W'(WR_LOW - 1);
    localparam logic [CNT_W-1:0] HIGH_TC = CNT_W'(WR_HIGH - 1);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic               beat;
    logic               beat_nx;
    logic               init_done;
    logic               done_set;
    logic               last_beat;

    logic               cmd_acc;
    logic               pix_acc;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [LW-1:0]      level;
    logic [16:0]        push_word;
    logic [16:0]        head;
    logic [16:0]        head_nx;
    logic [16:0]        src_word;
    logic [BUS_W-1:0]   bus_nx;
    logic               load;

    logic [5:0]         r6;
    logic [5:0]         g6;
    logic [5:0]         b6;
    logic [15:0]        pix_word;

    logic               wr_q;
    logic               rs_q;
    logic               reset_q;
    logic [BUS_W-1:0]   data_q;

    assign r6 = widen(5'(pix_r), CW, R_W);
    assign g6 = widen(5'(pix_g), CW, G_W);
    assign b6 = widen(5'(pix_b), CW, B_W);
    assign pix_word = ({10'b0, r6} << 11)
                    | ({10'b0, g6} << 5)
                    | {10'b0, b6};

    assign cmd_ready = init_done && !full;
    assign pix_ready = cmd_ready && !cmd_valid;
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign pix_acc   = pix_valid && pix_ready;
    assign push      = cmd_acc || pix_acc;
    assign push_word = cmd_acc ? {cmd_rs, cmd_data} : {1'b1, pix_word};

    tft_word_fifo #(
        .W     (17),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk28),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (push_word),
        .rd_en   (pop),
        .rd_data (head),
        .rd_next (head_nx),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign last_beat = (BEATS == 1) || beat;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_LO;
            cnt   <= '0;
            beat  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            beat  <= beat_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        beat_nx  = beat;
        pop      = 1'b0;
        done_set = 1'b0;
        unique case (state)
            RST_LO: begin
                if (cnt == RST_TC) begin
                    state_nx = RST_WAIT;
                    cnt_nx   = '0;
                end
            end
            RST_WAIT: begin
                if (cnt == RST_TC) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    done_set = 1'b1;
                end
            end
            IDLE: begin
                cnt_nx = '0;
                if (!empty) begin
                    state_nx = SETUP;
                    beat_nx  = 1'b0;
                end
            end
            SETUP: begin
                if (cnt == LOW_TC) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end
            end
            HOLD: begin
                if (cnt == HIGH_TC) begin
                    cnt_nx = '0;
                    if (!last_beat) begin
                        state_nx = SETUP;
                        beat_nx  = 1'b1;
                    end else begin
                        pop      = 1'b1;
                        beat_nx  = 1'b0;
                        state_nx = (level > LW'(1) || push) ? SETUP : IDLE;
                    end
                end
            end
            default: begin
                state_nx = RST_LO;
                cnt_nx   = '0;
            end
        endcase
    end

    // On a pop the next head is either the entry behind it or the word
    // being pushed on this very cycle into an otherwise drained FIFO.
    assign src_word = !pop           ? head    :
                      level > LW'(1) ? head_nx : push_word;
    assign load = (state_nx == SETUP) && (state != SETUP);

    if (BUS_W == 16) begin : g_bus16
        assign bus_nx = src_word[15:0];
    end else begin : g_bus8
        assign bus_nx = beat_nx ? src_word[7:0] : src_word[15:8];
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= 1'b1;
            rs_q      <= 1'b0;
            reset_q   <= 1'b0;
            data_q    <= '0;
            init_done <= 1'b0;
        end else begin
            wr_q    <= (state_nx != SETUP);
            reset_q <= (state_nx != RST_LO);
            if (done_set) init_done <= 1'b1;
            if (load) begin
                rs_q   <= src_word[16];
                data_q <= bus_nx;
            end
        end
    end

    assign busy       = (state != IDLE) || !empty;
    assign fifo_level = level;
    assign tftRD      = 1'b1;
    assign tftWR      = wr_q;
    assign tftRS      = rs_q;
    assign tftRESET   = reset_q;
    assign tftData    = data_q;

endmodule

// File: tb/tb_tft_bus_master.sv
// Directed bench for tft_bus_master: a 16-bit instance with a 4-deep FIFO
// and an 8-bit instance, both with a 10-cycle reset phase.
module tb_tft_bus_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid16 = 0, cmd_rs16 = 0;
    logic [15:0] cmd_data16 = 0;
    logic        cmd_ready16, pix_ready16, busy16;
    logic        pix_valid16 = 0;
    logic [2:0]  pix_r16 = 0, pix_g16 = 0, pix_b16 = 0;
    logic [2:0]  fifo_level16;
    logic        tftRD16, tftWR16, tftRS16, tftRESET16;
    logic [15:0] tftData16;

    logic        cmd_valid8 = 0, cmd_rs8 = 0;
    logic [15:0] cmd_data8 = 0;
    logic        cmd_ready8, pix_ready8, busy8;
    logic        pix_valid8 = 0;
    logic [2:0]  pix_r8 = 0, pix_g8 = 0, pix_b8 = 0;
    logic [4:0]  fifo_level8;
    logic        tftRD8, tftWR8, tftRS8, tftRESET8;
    logic [7:0]  tftData8;

    tft_bus_master #(
        .BUS_W(16), .CW(3), .FIFO_DEPTH(4),
        .WR_LOW(2), .WR_HIGH(2), .RST_CYCLES(10)
    ) u16 (
        .clk28(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid16), .cmd_rs(cmd_rs16),
        .cmd_data(cmd_data16), .cmd_ready(cmd_ready16),
        .pix_valid(pix_valid16), .pix_r(pix_r16),
        .pix_g(pix_g16), .pix_b(pix_b16),
        .pix_ready(pix_ready16), .busy(busy16),
        .fifo_level(fifo_level16), .tftRD(tftRD16),
        .tftWR(tftWR16), .tftRS(tftRS16),
        .tftRESET(tftRESET16), .tftData(tftData16)
    );

    tft_bus_master #(
        .BUS_W(8), .CW(3), .FIFO_DEPTH(16),
        .WR_LOW(2), .WR_HIGH(2), .RST_CYCLES(10)
    ) u8 (
        .clk28(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid8), .cmd_rs(cmd_rs8),
        .cmd_data(cmd_data8), .cmd_ready(cmd_ready8),
        .pix_valid(pix_valid8), .pix_r(pix_r8),
        .pix_g(pix_g8), .pix_b(pix_b8),
        .pix_ready(pix_ready8), .busy(busy8),
        .fifo_level(fifo_level8), .tftRD(tftRD8),
        .tftWR(tftWR8), .tftRS(tftRS8),
        .tftRESET(tftRESET8), .tftData(tftData8)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CW=3 packing written out by hand: {r,r[2:1]} {g,g} {b,b[2:1]}
    function automatic logic [15:0] exp565(input logic [2:0] r,
                                           input logic [2:0] g,
                                           input logic [2:0] b);
        return {r, r[2:1], g, g, b, b[2:1]};
    endfunction

    logic [16:0] mon_q[$];
    logic        wr_prev16 = 1'b1;
    always @(negedge clk) begin
        if (wr_prev16 && !tftWR16) mon_q.push_back({tftRS16, tftData16});
        wr_prev16 = tftWR16;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic reset_seq(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 9)  check({tag, "_rst_lo"}, tftRESET16, 0);
            if (i == 10) check({tag, "_rst_hi"}, tftRESET16, 1);
            if (i == 19) check({tag, "_rdy_lo"}, cmd_ready16, 0);
            if (i == 20) begin
                check({tag, "_rdy_hi"}, cmd_ready16, 1);
                check({tag, "_rdy8_hi"}, cmd_ready8, 1);
            end
        end
    endtask

    logic [8:0]  wr_tbl;
    logic [15:0] exp_q[$];
    logic [2:0]  pr, pg, pb;
    int          max_lvl;
    logic        rdy_full;
    logic        ok;

    initial begin
        // reset values
        repeat (3) @(negedge clk);
        check("r_tftRESET", tftRESET16, 0);
        check("r_tftWR", tftWR16, 1);
        check("r_tftRD", tftRD16, 1);
        check("r_tftRS", tftRS16, 0);
        check("r_tftData", tftData16, 0);
        check("r_cmd_ready", cmd_ready16, 0);
        check("r_pix_ready", pix_ready16, 0);
        check("r_busy", busy16, 1);
        check("r_level", fifo_level16, 0);
        check("r8_tftData", tftData8, 0);
        check("r8_tftWR", tftWR8, 1);

        reset_seq("init");

        // command and pixel together: command wins
        cmd_valid16 = 1; cmd_rs16 = 0; cmd_data16 = 16'h002C;
        pix_valid16 = 1; pix_r16 = 3'd7; pix_g16 = 3'd0; pix_b16 = 3'd5;
        #1;
        check("arb_cmd_ready", cmd_ready16, 1);
        check("arb_pix_ready", pix_ready16, 0);
        @(negedge clk);
        cmd_valid16 = 0;
        #1;
        check("arb_pix_next", pix_ready16, 1);
        check("lat_level1", fifo_level16, 1);
        check("lat_wr_hi", tftWR16, 1);
        wr_tbl = 9'b111001100;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            pix_valid16 = 0;
            check("seq_wr", tftWR16, wr_tbl[k]);
            if (k == 0) begin
                check("b0_rs", tftRS16, 0);
                check("b0_data", tftData16, 16'h002C);
                check("b0_level", fifo_level16, 2);
            end
            if (k == 4 || k == 6) begin
                check("b1_rs", tftRS16, 1);
                check("b1_data", tftData16, 16'hF816);
            end
            if (k == 8) begin
                check("b1_idle_busy", busy16, 0);
                check("b1_idle_level", fifo_level16, 0);
                check("b1_idle_data", tftData16, 16'hF816);
            end
        end

        // 8-bit bus: 0x6DA4 as two beats
        @(negedge clk);
        pix_valid8 = 1; pix_r8 = 3'd3; pix_g8 = 3'd5; pix_b8 = 3'd1;
        #1;
        check("b8_ready", pix_ready8, 1);
        @(negedge clk);
        pix_valid8 = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("b8_hi_wr", tftWR8, 0);
                check("b8_hi_rs", tftRS8, 1);
                check("b8_hi_data", tftData8, 8'h6D);
            end
            if (k == 3) begin
                check("b8_hi_hold_wr", tftWR8, 1);
                check("b8_hi_hold_data", tftData8, 8'h6D);
            end
            if (k == 5) begin
                check("b8_lo_wr", tftWR8, 0);
                check("b8_lo_rs", tftRS8, 1);
                check("b8_lo_data", tftData8, 8'hA4);
            end
            if (k == 7) begin
                check("b8_lo_hold_wr", tftWR8, 1);
                check("b8_lo_hold_data", tftData8, 8'hA4);
            end
            if (k == 9) check("b8_done_busy", busy8, 0);
        end

        // overfill the 4-deep FIFO and check ordering
        mon_q.delete();
        max_lvl = 0;
        rdy_full = 0;
        for (int i = 0; i < 8; i++) begin
            pr = 3'(i); pg = 3'(i * 3); pb = 3'(7 - i);
            pix_r16 = pr; pix_g16 = pg; pix_b16 = pb;
            pix_valid16 = 1;
            exp_q.push_back(exp565(pr, pg, pb));
            ok = 0;
            for (int t = 0; t < 100 && !ok; t++) begin
                #1;
                if (int'(fifo_level16) > max_lvl) max_lvl = int'(fifo_level16);
                if (fifo_level16 == 3'd4 && pix_ready16) rdy_full = 1;
                ok = pix_ready16;
                @(negedge clk);
            end
            check("fill_accept", ok, 1);
        end
        pix_valid16 = 0;
        check("fill_max_level", max_lvl, 4);
        check("fill_ready_when_full", rdy_full, 0);
        for (int t = 0; t < 400 && busy16; t++) @(negedge clk);
        check("fill_drain", busy16, 0);
        check("fill_count", mon_q.size(), 8);
        for (int i = 0; i < 8 && i < mon_q.size(); i++)
            check("fill_word", mon_q[i], {1'b1, exp_q[i]});

        // reset pulse during HOLD of the first beat
        cmd_valid16 = 1; cmd_rs16 = 0; cmd_data16 = 16'h1234;
        @(negedge clk);
        cmd_valid16 = 0;
        repeat (3) @(negedge clk);
        check("mid_hold_wr", tftWR16, 1);
        check("mid_hold_data", tftData16, 16'h1234);
        #2 rst_n = 0;
        #1;
        check("mid_rst_wr", tftWR16, 1);
        check("mid_rst_reset", tftRESET16, 0);
        check("mid_rst_level", fifo_level16, 0);
        check("mid_rst_data", tftData16, 0);
        check("mid_rst_busy", busy16, 1);
        check("mid_rst_cmd_ready", cmd_ready16, 0);
        reset_seq("again");
        check("again_level", fifo_level16, 0);
        check("again_busy", busy16, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
